// File: rtl/div_result_receiver.sv
// Host-side receiver for the int16 divider: issues an operand pair, gathers the
// four LSB-first result bytes and presents the float quotient with class/error status.
module div_result_receiver #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned TO_W    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   output logic        cmd_ready,
   output logic        enable,
   output logic [15:0] a,
   output logic [15:0] b,
   input  logic        dut_ready,
   input  logic [7:0]  dut_out,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic [1:0]  res_class,
   output logic [1:0]  res_err
);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StRecv, StDone} state_e;

   localparam logic [1:0] ErrOk      = 2'b00;
   localparam logic [1:0] ErrTimeout = 2'b01;
   localparam logic [1:0] ErrFrame   = 2'b10;

   state_e            state_q, state_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [2:0]        byte_cnt_q, byte_cnt_d;
   logic [31:0]       asm_q, asm_d;
   logic [15:0]       a_q, a_d, b_q, b_d;
   logic [31:0]       res_data_q, res_data_d;
   logic [1:0]        res_class_q, res_class_d;
   logic [1:0]        res_err_q, res_err_d;

   function automatic logic [1:0] classify(input logic [31:0] w);
      logic [7:0]  exp_f;
      logic [22:0] man_f;
      exp_f = w[30:23];
      man_f = w[22:0];
      if (exp_f == 8'h00 && man_f == 23'd0)      classify = 2'b01;
      else if (exp_f == 8'hFF && man_f == 23'd0) classify = 2'b10;
      else if (exp_f == 8'hFF)                   classify = 2'b11;
      else                                       classify = 2'b00;
   endfunction

   always_comb begin
      state_d     = state_q;
      to_cnt_d    = to_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      asm_d       = asm_q;
      a_d         = a_q;
      b_d         = b_q;
      res_data_d  = res_data_q;
      res_class_d = res_class_q;
      res_err_d   = res_err_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               a_d     = cmd_a;
               b_d     = cmd_b;
               state_d = StIssue;
            end
         end
         StIssue: begin
            to_cnt_d   = '0;
            byte_cnt_d = '0;
            asm_d      = '0;
            state_d    = StWait;
         end
         StWait: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (dut_ready) begin
               asm_d[7:0] = dut_out;
               byte_cnt_d = 3'd1;
               state_d    = StRecv;
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               res_data_d  = '0;
               res_class_d = classify(32'd0);
               res_err_d   = ErrTimeout;
               state_d     = StDone;
            end
         end
         StRecv: begin
            if (dut_ready) begin
               asm_d[{byte_cnt_q[1:0], 3'b000} +: 8] = dut_out;
               byte_cnt_d = byte_cnt_q + 3'd1;
               if (byte_cnt_q == 3'd3) begin
                  res_data_d  = asm_d;
                  res_class_d = classify(asm_d);
                  res_err_d   = ErrOk;
                  state_d     = StDone;
               end
            end else begin
               // Bytes never received stay zero because asm_q is cleared in ISSUE.
               res_data_d  = asm_q;
               res_class_d = classify(asm_q);
               res_err_d   = ErrFrame;
               state_d     = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         to_cnt_q    <= '0;
         byte_cnt_q  <= '0;
         asm_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_data_q  <= '0;
         res_class_q <= '0;
         res_err_q   <= '0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         asm_q       <= asm_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_data_q  <= res_data_d;
         res_class_q <= res_class_d;
         res_err_q   <= res_err_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign enable    = (state_q == StIssue);
   assign res_valid = (state_q == StDone);
   assign a         = a_q;
   assign b         = b_q;
   assign res_data  = res_data_q;
   assign res_class = res_class_q;
   assign res_err   = res_err_q;

endmodule

// File: tb/tb_div_result_receiver.sv
// Scoreboard bench for div_result_receiver: the driver queues expected results,
// the monitor checks them whenever res_valid is seen.
module tb_div_result_receiver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [15:0] cmd_a = '0;
   logic [15:0] cmd_b = '0;
   logic        cmd_ready;
   logic        enable;
   logic [15:0] a;
   logic [15:0] b;
   logic        dut_ready = 1'b0;
   logic [7:0]  dut_out = '0;
   logic        res_valid;
   logic [31:0] res_data;
   logic [1:0]  res_class;
   logic [1:0]  res_err;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  cls;
      logic [1:0]  err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   en_cnt = 0;

   div_result_receiver #(.TIMEOUT(64), .TO_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_ready (cmd_ready),
      .enable    (enable),
      .a         (a),
      .b         (b),
      .dut_ready (dut_ready),
      .dut_out   (dut_out),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_class (res_class),
      .res_err   (res_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every res_valid must match the oldest queued expectation.
   always @(negedge clk) begin
      if (enable === 1'b1) en_cnt++;
      if (res_valid !== 1'b0) begin
         if (sb.size() == 0) begin
            chk("unexpected_res_valid", {31'd0, res_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_class", {30'd0, res_class}, {30'd0, e.cls});
            chk("res_err", {30'd0, res_err}, {30'd0, e.err});
         end
      end
   end

   task automatic wait_res_valid(input string name);
      bit seen = 0;
      for (int i = 0; i < 200; i++) begin
         if (res_valid === 1'b1) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
   endtask

   // Called at a negedge with the block idle; returns at a negedge with the block idle.
   task automatic run_frame(input string name, input logic [15:0] ca, input logic [15:0] cb,
                            input logic [31:0] bytes, input int nb,
                            input logic [31:0] ed, input logic [1:0] ec, input logic [1:0] ee);
      int en0;
      exp_t e;
      e.data = ed;
      e.cls  = ec;
      e.err  = ee;
      sb.push_back(e);
      chk({name, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_a     = ca;
      cmd_b     = cb;
      en0       = en_cnt;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({name, "_enable"}, {31'd0, enable}, 32'd1);
      chk({name, "_a"}, {16'd0, a}, {16'd0, ca});
      chk({name, "_b"}, {16'd0, b}, {16'd0, cb});
      @(negedge clk);
      for (int k = 0; k < nb; k++) begin
         dut_ready = 1'b1;
         dut_out   = bytes[8*k +: 8];
         @(negedge clk);
      end
      dut_ready = 1'b0;
      dut_out   = '0;
      wait_res_valid(name);
      chk({name, "_enable_once"}, en_cnt - en0, 32'd1);
      chk({name, "_idle_after"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_enable", {31'd0, enable}, 32'd0);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Bytes listed LSB-first in the low byte of 'bytes'.
      run_frame("f_7_2",   16'h0007, 16'h0002, 32'h40600000, 4, 32'h40600000, 2'b00, 2'b00);
      run_frame("f_m6_3",  16'hFFFA, 16'h0003, 32'hC0000000, 4, 32'hC0000000, 2'b00, 2'b00);
      run_frame("f_5_0",   16'h0005, 16'h0000, 32'h7F800000, 4, 32'h7F800000, 2'b10, 2'b00);
      run_frame("f_0_0",   16'h0000, 16'h0000, 32'h7FC00000, 4, 32'h7FC00000, 2'b11, 2'b00);
      run_frame("f_0_9",   16'h0000, 16'h0009, 32'h00000000, 4, 32'h00000000, 2'b01, 2'b00);
      chk("hold_res_data", res_data, 32'h00000000);
      run_frame("f_frame", 16'h0011, 16'h0022, 32'h0000BBAA, 2, 32'h0000BBAA, 2'b00, 2'b10);
      chk("hold_a", {16'd0, a}, 32'h0011);

      // Timeout: enable to res_valid is 65 cycles.
      sb.push_back('{data: 32'd0, cls: 2'b01, err: 2'b01});
      cmd_valid = 1'b1;
      cmd_a     = 16'h0003;
      cmd_b     = 16'h0004;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("to_enable", {31'd0, enable}, 32'd1);
      n = 0;
      while (res_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("to_latency", n, 32'd65);
      chk("to_cmd_ready_done", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      chk("to_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

      // Reset during RECV after two bytes.
      cmd_valid = 1'b1;
      cmd_a     = 16'h1234;
      cmd_b     = 16'h5678;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      dut_ready = 1'b1;
      dut_out   = 8'h11;
      @(negedge clk);
      dut_out   = 8'h22;
      @(negedge clk);
      dut_out   = 8'h33;
      rst_n     = 1'b0;
      @(negedge clk);
      chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("mid_rst_enable", {31'd0, enable}, 32'd0);
      chk("mid_rst_a", {16'd0, a}, 32'd0);
      chk("mid_rst_b", {16'd0, b}, 32'd0);
      chk("mid_rst_res_data", res_data, 32'd0);
      chk("mid_rst_class_err", {28'd0, res_class, res_err}, 32'd0);
      rst_n = 1'b1;
      // Stray bytes in IDLE must be ignored (the monitor flags any res_valid).
      repeat (3) @(negedge clk);
      chk("stray_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      dut_ready = 1'b0;
      dut_out   = '0;
      @(negedge clk);
      run_frame("f_1_1", 16'h0001, 16'h0001, 32'h3F800000, 4, 32'h3F800000, 2'b00, 2'b00);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
